// File: rtl/cache_pkg.sv
// Shared types and response codes for the cache front-end port arbiter.
package cache_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ISSUE = 2'b01,
      ST_WAIT  = 2'b10
   } arb_state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/core_port_arbiter.sv
// Round-robin arbiter sharing the blocking cache core port between two requesters,
// with a response watchdog that synthesizes SLVERR when downstream goes silent.
module core_port_arbiter
   import cache_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [1:0]                  rq_valid,
   output logic [1:0]                  rq_ready,
   input  logic [1:0]                  rq_we,
   input  logic [2*ADDR_WIDTH-1:0]     rq_addr,
   input  logic [2*DATA_WIDTH-1:0]     rq_wdata,
   input  logic [2*DATA_WIDTH/8-1:0]   rq_wstrb,
   output logic [1:0]                  rs_valid,
   output logic                        rs_is_write,
   output logic [DATA_WIDTH-1:0]       rs_rdata,
   output logic [1:0]                  rs_resp,
   output logic                        m_req_valid,
   input  logic                        m_req_ready,
   output logic                        m_req_we,
   output logic [ADDR_WIDTH-1:0]       m_req_addr,
   output logic [DATA_WIDTH-1:0]       m_req_wdata,
   output logic [DATA_WIDTH/8-1:0]     m_req_wstrb,
   input  logic                        m_resp_valid,
   input  logic                        m_resp_is_write,
   input  logic [DATA_WIDTH-1:0]       m_resp_rdata,
   input  logic [1:0]                  m_resp_resp,
   output logic                        timeout_err,
   output logic                        late_resp,
   output logic [1:0]                  dbg_state,
   output logic                        dbg_owner
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int WD_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   arb_state_t              state_q, state_d;
   logic                    rr_ptr_q, rr_ptr_d;
   logic                    owner_q, owner_d;
   logic [WD_W-1:0]         wd_cnt_q, wd_cnt_d;
   logic                    we_q, we_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [STRB_W-1:0]       wstrb_q, wstrb_d;
   logic [1:0]              rs_valid_q, rs_valid_d;
   logic                    rs_is_write_q, rs_is_write_d;
   logic [DATA_WIDTH-1:0]   rs_rdata_q, rs_rdata_d;
   logic [1:0]              rs_resp_q, rs_resp_d;
   logic                    timeout_err_q, timeout_err_d;
   logic                    late_resp_q, late_resp_d;
   logic                    winner;

   // Contention goes to the pointer; a lone requester always wins.
   function automatic logic pick_winner(input logic [1:0] v, input logic rr);
      if (v[0] && v[1]) return rr;
      return v[1];
   endfunction

   always_comb begin
      state_d       = state_q;
      rr_ptr_d      = rr_ptr_q;
      owner_d       = owner_q;
      wd_cnt_d      = wd_cnt_q;
      we_d          = we_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      wstrb_d       = wstrb_q;
      rs_valid_d    = 2'b00;
      rs_is_write_d = rs_is_write_q;
      rs_rdata_d    = rs_rdata_q;
      rs_resp_d     = rs_resp_q;
      timeout_err_d = timeout_err_q;
      late_resp_d   = late_resp_q;
      rq_ready      = 2'b00;
      winner        = pick_winner(rq_valid, rr_ptr_q);

      if (m_resp_valid && (state_q != ST_WAIT)) late_resp_d = 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (|rq_valid) begin
               rq_ready[winner] = 1'b1;
               owner_d = winner;
               we_d    = rq_we[winner];
               addr_d  = winner ? rq_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : rq_addr[ADDR_WIDTH-1:0];
               wdata_d = winner ? rq_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : rq_wdata[DATA_WIDTH-1:0];
               wstrb_d = winner ? rq_wstrb[2*STRB_W-1:STRB_W] : rq_wstrb[STRB_W-1:0];
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (m_req_ready) begin
               wd_cnt_d = '0;
               state_d  = ST_WAIT;
            end
         end
         ST_WAIT: begin
            wd_cnt_d = wd_cnt_q + 1'b1;
            // A real response beats a simultaneous watchdog expiry.
            if (m_resp_valid) begin
               rs_valid_d[owner_q] = 1'b1;
               rs_is_write_d = m_resp_is_write;
               rs_rdata_d    = m_resp_rdata;
               rs_resp_d     = m_resp_resp;
               rr_ptr_d      = ~owner_q;
               state_d       = ST_IDLE;
            end else if (wd_cnt_q == WD_LAST) begin
               rs_valid_d[owner_q] = 1'b1;
               rs_is_write_d = we_q;
               rs_rdata_d    = '0;
               rs_resp_d     = RESP_SLVERR;
               timeout_err_d = 1'b1;
               rr_ptr_d      = ~owner_q;
               state_d       = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         rr_ptr_q      <= 1'b0;
         owner_q       <= 1'b0;
         wd_cnt_q      <= '0;
         we_q          <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
         rs_valid_q    <= 2'b00;
         rs_is_write_q <= 1'b0;
         rs_rdata_q    <= '0;
         rs_resp_q     <= RESP_OKAY;
         timeout_err_q <= 1'b0;
         late_resp_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         owner_q       <= owner_d;
         wd_cnt_q      <= wd_cnt_d;
         we_q          <= we_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         wstrb_q       <= wstrb_d;
         rs_valid_q    <= rs_valid_d;
         rs_is_write_q <= rs_is_write_d;
         rs_rdata_q    <= rs_rdata_d;
         rs_resp_q     <= rs_resp_d;
         timeout_err_q <= timeout_err_d;
         late_resp_q   <= late_resp_d;
      end
   end

   assign m_req_valid = (state_q == ST_ISSUE);
   assign m_req_we    = we_q;
   assign m_req_addr  = addr_q;
   assign m_req_wdata = wdata_q;
   assign m_req_wstrb = wstrb_q;
   assign rs_valid    = rs_valid_q;
   assign rs_is_write = rs_is_write_q;
   assign rs_rdata    = rs_rdata_q;
   assign rs_resp     = rs_resp_q;
   assign timeout_err = timeout_err_q;
   assign late_resp   = late_resp_q;
   assign dbg_state   = state_q;
   assign dbg_owner   = owner_q;

endmodule

// File: tb/tb_core_port_arbiter.sv
// Directed bench for core_port_arbiter: table of arbitration rounds plus hand-built stall,
// timeout, late-response and reset sequences.
module tb_core_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;
   localparam int T  = 8;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [1:0]      rq_valid;
   logic [1:0]      rq_ready;
   logic [1:0]      rq_we;
   logic [2*AW-1:0] rq_addr;
   logic [2*DW-1:0] rq_wdata;
   logic [2*SW-1:0] rq_wstrb;
   logic [1:0]      rs_valid;
   logic            rs_is_write;
   logic [DW-1:0]   rs_rdata;
   logic [1:0]      rs_resp;
   logic            m_req_valid;
   logic            m_req_ready;
   logic            m_req_we;
   logic [AW-1:0]   m_req_addr;
   logic [DW-1:0]   m_req_wdata;
   logic [SW-1:0]   m_req_wstrb;
   logic            m_resp_valid;
   logic            m_resp_is_write;
   logic [DW-1:0]   m_resp_rdata;
   logic [1:0]      m_resp_resp;
   logic            timeout_err;
   logic            late_resp;
   logic [1:0]      dbg_state;
   logic            dbg_owner;

   int n_chk  = 0;
   int n_fail = 0;

   core_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst_n(rst_n),
      .rq_valid(rq_valid), .rq_ready(rq_ready), .rq_we(rq_we), .rq_addr(rq_addr),
      .rq_wdata(rq_wdata), .rq_wstrb(rq_wstrb),
      .rs_valid(rs_valid), .rs_is_write(rs_is_write), .rs_rdata(rs_rdata), .rs_resp(rs_resp),
      .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_we(m_req_we),
      .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata), .m_req_wstrb(m_req_wstrb),
      .m_resp_valid(m_resp_valid), .m_resp_is_write(m_resp_is_write),
      .m_resp_rdata(m_resp_rdata), .m_resp_resp(m_resp_resp),
      .timeout_err(timeout_err), .late_resp(late_resp),
      .dbg_state(dbg_state), .dbg_owner(dbg_owner)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  valid;
      logic [1:0]  we;
      logic [31:0] a0;
      logic [31:0] a1;
      logic [1:0]  exp_ready;
      logic [31:0] exp_addr;
      logic        exp_we;
      logic [31:0] rdata;
      logic [1:0]  resp;
      int          lat;
   } vec_t;

   vec_t tbl[9];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
   endtask

   // One full arbitration round from IDLE; all expectations come from the vector.
   task automatic run_txn(input vec_t v, input string tag);
      rq_valid = v.valid;
      rq_we    = v.we;
      rq_addr  = {v.a1, v.a0};
      rq_wdata = {v.a1 ^ 32'hB0B0_0000, v.a0 ^ 32'hA0A0_0000};
      rq_wstrb = 8'h3C;
      #1;
      chk({tag, "_grant"}, 32'(rq_ready), 32'(v.exp_ready));
      tick;
      chk({tag, "_m_req_valid"}, 32'(m_req_valid), 32'd1);
      chk({tag, "_m_req_addr"}, m_req_addr, v.exp_addr);
      chk({tag, "_m_req_we"}, 32'(m_req_we), 32'(v.exp_we));
      rq_valid    = 2'b00;
      m_req_ready = 1'b1;
      tick;
      m_req_ready = 1'b0;
      chk({tag, "_wait_state"}, 32'(dbg_state), 32'd2);
      repeat (v.lat) tick;
      m_resp_valid    = 1'b1;
      m_resp_is_write = v.exp_we;
      m_resp_rdata    = v.rdata;
      m_resp_resp     = v.resp;
      tick;
      m_resp_valid = 1'b0;
      chk({tag, "_rs_valid"}, 32'(rs_valid), 32'(v.exp_ready));
      chk({tag, "_rs_rdata"}, rs_rdata, v.rdata);
      chk({tag, "_rs_resp"}, 32'(rs_resp), 32'(v.resp));
      chk({tag, "_rs_is_write"}, 32'(rs_is_write), 32'(v.exp_we));
      chk({tag, "_idle"}, 32'(dbg_state), 32'd0);
      tick;
      chk({tag, "_rs_pulse_end"}, 32'(rs_valid), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "bench time limit");
   end

   initial begin
      int   cnt;
      vec_t v;

      // valid, we, a0, a1, exp_ready, exp_addr, exp_we, rdata, resp, lat
      tbl[0] = '{2'b11, 2'b01, 32'h100, 32'h104, 2'b01, 32'h100, 1'b1, 32'h0000_0000, 2'b00, 1};
      tbl[1] = '{2'b11, 2'b00, 32'h200, 32'h204, 2'b10, 32'h204, 1'b0, 32'hA5A5_0001, 2'b00, 0};
      tbl[2] = '{2'b11, 2'b10, 32'h300, 32'h304, 2'b01, 32'h300, 1'b0, 32'hDEAD_BEEF, 2'b10, 3};
      tbl[3] = '{2'b01, 2'b00, 32'h400, 32'h404, 2'b01, 32'h400, 1'b0, 32'h0000_0404, 2'b00, 2};
      tbl[4] = '{2'b10, 2'b10, 32'h500, 32'h504, 2'b10, 32'h504, 1'b1, 32'h0000_0000, 2'b00, 5};
      tbl[5] = '{2'b10, 2'b00, 32'h600, 32'h604, 2'b10, 32'h604, 1'b0, 32'h6060_6060, 2'b11, 1};
      tbl[6] = '{2'b11, 2'b00, 32'h700, 32'h704, 2'b01, 32'h700, 1'b0, 32'h7777_0000, 2'b00, 0};
      tbl[7] = '{2'b01, 2'b01, 32'h800, 32'h804, 2'b01, 32'h800, 1'b1, 32'h0000_0000, 2'b00, 2};
      tbl[8] = '{2'b11, 2'b11, 32'h900, 32'h904, 2'b10, 32'h904, 1'b1, 32'h0000_0000, 2'b00, 4};

      rst_n = 1'b0;
      rq_valid = 2'b00; rq_we = 2'b00; rq_addr = '0; rq_wdata = '0; rq_wstrb = '0;
      m_req_ready = 1'b0; m_resp_valid = 1'b0; m_resp_is_write = 1'b0;
      m_resp_rdata = '0; m_resp_resp = 2'b00;
      tick;
      tick;
      chk("rst_state", 32'(dbg_state), 32'd0);
      chk("rst_rq_ready", 32'(rq_ready), 32'd0);
      chk("rst_m_req_valid", 32'(m_req_valid), 32'd0);
      chk("rst_m_req_addr", m_req_addr, 32'd0);
      chk("rst_rs_valid", 32'(rs_valid), 32'd0);
      chk("rst_flags", {30'd0, timeout_err, late_resp}, 32'd0);
      rst_n = 1'b1;

      // Single read from requester 0, response after 4 WAIT cycles.
      v = '{2'b01, 2'b00, 32'h10, 32'h0, 2'b01, 32'h10, 1'b0, 32'h1234_5678, 2'b00, 4};
      run_txn(v, "single_read");

      // Both valid out of reset: req0 first, req1 granted in the response cycle.
      do_reset;
      rq_valid = 2'b11; rq_we = 2'b01; rq_addr = {32'h30, 32'h20};
      #1;
      chk("both_grant0", 32'(rq_ready), 32'b01);
      tick;
      chk("both_addr0", m_req_addr, 32'h20);
      rq_valid = 2'b10;
      m_req_ready = 1'b1;
      tick;
      m_req_ready = 1'b0;
      chk("both_no_grant_in_wait", 32'(rq_ready), 32'd0);
      tick;
      tick;
      m_resp_valid = 1'b1; m_resp_is_write = 1'b1; m_resp_rdata = 32'h0; m_resp_resp = 2'b00;
      tick;
      m_resp_valid = 1'b0;
      chk("both_rs0", 32'(rs_valid), 32'b01);
      chk("both_grant1_same_cycle", 32'(rq_ready), 32'b10);
      tick;
      rq_valid = 2'b00;
      chk("both_addr1", m_req_addr, 32'h30);
      chk("both_we1", 32'(m_req_we), 32'd0);
      m_req_ready = 1'b1;
      tick;
      m_req_ready = 1'b0;
      m_resp_valid = 1'b1; m_resp_is_write = 1'b0; m_resp_rdata = 32'h3030_3030;
      tick;
      m_resp_valid = 1'b0;
      chk("both_rs1", 32'(rs_valid), 32'b10);
      chk("both_rdata1", rs_rdata, 32'h3030_3030);

      // Downstream back-pressure: request must hold steady for 5 cycles.
      rq_valid = 2'b01; rq_we = 2'b01; rq_addr = {32'h0, 32'h44};
      rq_wdata = {32'h0, 32'h4444_5555}; rq_wstrb = 8'h0A;
      tick;
      rq_valid = 2'b00;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("stall%0d_valid", i), 32'(m_req_valid), 32'd1);
         chk($sformatf("stall%0d_addr", i), m_req_addr, 32'h44);
         chk($sformatf("stall%0d_wdata", i), m_req_wdata, 32'h4444_5555);
         chk($sformatf("stall%0d_wstrb", i), 32'(m_req_wstrb), 32'hA);
         tick;
      end
      m_req_ready = 1'b1;
      tick;
      m_req_ready = 1'b0;
      chk("stall_wait_state", 32'(dbg_state), 32'd2);
      chk("stall_single_handshake", 32'(m_req_valid), 32'd0);
      m_resp_valid = 1'b1; m_resp_is_write = 1'b1; m_resp_rdata = 32'h0;
      tick;
      m_resp_valid = 1'b0;
      chk("stall_rs0", 32'(rs_valid), 32'b01);

      // Round-robin table starts from a fresh pointer.
      do_reset;
      for (int i = 0; i < 9; i++) run_txn(tbl[i], $sformatf("row%0d", i));

      // Watchdog: owner 1 write, downstream never answers.
      rq_valid = 2'b10; rq_we = 2'b10; rq_addr = {32'h55, 32'h0};
      tick;
      rq_valid = 2'b00;
      m_req_ready = 1'b1;
      tick;
      m_req_ready = 1'b0;
      cnt = 0;
      while (cnt < 4 * T) begin
         tick;
         cnt++;
         if (rs_valid != 2'b00) break;
      end
      chk("to_latency", 32'(cnt), 32'(T));
      chk("to_rs_valid", 32'(rs_valid), 32'b10);
      chk("to_rs_resp", 32'(rs_resp), 32'b10);
      chk("to_rs_rdata", rs_rdata, 32'd0);
      chk("to_rs_is_write", 32'(rs_is_write), 32'd1);
      chk("to_timeout_err", 32'(timeout_err), 32'd1);
      chk("to_no_late_yet", 32'(late_resp), 32'd0);
      m_resp_valid = 1'b1; m_resp_rdata = 32'hFFFF_FFFF;
      tick;
      m_resp_valid = 1'b0;
      chk("late_flag", 32'(late_resp), 32'd1);
      chk("late_no_rs", 32'(rs_valid), 32'd0);
      chk("late_idle", 32'(dbg_state), 32'd0);
      chk("late_timeout_sticky", 32'(timeout_err), 32'd1);

      // Reset in the middle of WAIT aborts silently.
      rq_valid = 2'b10; rq_we = 2'b00; rq_addr = {32'h66, 32'h0};
      tick;
      rq_valid = 2'b00;
      m_req_ready = 1'b1;
      tick;
      m_req_ready = 1'b0;
      tick;
      chk("mid_wait_state", 32'(dbg_state), 32'd2);
      do_reset;
      chk("mr_state", 32'(dbg_state), 32'd0);
      chk("mr_owner", 32'(dbg_owner), 32'd0);
      chk("mr_m_req", {31'd0, m_req_valid} | m_req_addr, 32'd0);
      chk("mr_rs_valid", 32'(rs_valid), 32'd0);
      chk("mr_rs_data", rs_rdata | 32'(rs_resp) | 32'(rs_is_write), 32'd0);
      chk("mr_flags", {30'd0, timeout_err, late_resp}, 32'd0);
      for (int i = 0; i < T + 2; i++) begin
         tick;
         chk($sformatf("mr_quiet%0d", i), 32'(rs_valid), 32'd0);
      end

      // Fresh request; response lands in the watchdog's final cycle and must win.
      v = '{2'b01, 2'b00, 32'h77, 32'h0, 2'b01, 32'h77, 1'b0, 32'hCAFE_F00D, 2'b00, T - 1};
      run_txn(v, "post_reset");
      chk("tie_no_timeout", 32'(timeout_err), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/core_port_arbiter.md
# core_port_arbiter

Two-requester arbiter sharing the single blocking core request/response port of the direct-mapped cache between two `cpu_translator` instances (e.g. instruction and data AXI4-Lite slaves). It accepts one request at a time, round-robin between requesters, and forwards it downstream. It returns the matching response only to the owning requester. A watchdog converts a lost downstream response into SLVERR so no translator FSM hangs.

## Interface
Parameters:
- ADDR_WIDTH, 32, request address width
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8
- TIMEOUT_CYCLES, 64, WAIT cycles before a synthesized SLVERR; minimum 2

Ports (index i ∈ {0,1}; packed vectors hold requester i at slice i):
- clk  in  1  clock; all logic rising-edge
- rst_n  in  1  reset, synchronous, active-low
- rq_valid  in  2  request valid per requester
- rq_ready  out  2  request accepted (at most one bit set)
- rq_we  in  2  1 = write
- rq_addr  in  2*ADDR_WIDTH  request address
- rq_wdata  in  2*DATA_WIDTH  write data
- rq_wstrb  in  2*DATA_WIDTH/8  byte strobes
- rs_valid  out  2  one-cycle response pulse to the owner
- rs_is_write  out  1  response belongs to a write
- rs_rdata  out  DATA_WIDTH  read data, shared by both requesters
- rs_resp  out  2  AXI response code
- m_req_valid, m_req_ready  out/in  1  downstream request handshake
- m_req_we, m_req_addr, m_req_wdata, m_req_wstrb  out  1/ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8  registered request payload
- m_resp_valid  in  1  downstream response pulse; no back-pressure
- m_resp_is_write, m_resp_rdata, m_resp_resp  in  1/DATA_WIDTH/2  response payload
- timeout_err  out  1  sticky; set on watchdog expiry
- late_resp  out  1  sticky; set on an m_resp_valid received outside WAIT
- dbg_state  out  2  FSM state encoding
- dbg_owner  out  1  current owner index

## Operation
- FSM: IDLE=2'b00, ISSUE=2'b01, WAIT=2'b10. Encoding 2'b11 is unused and recovers to IDLE.
- IDLE: with any rq_valid, the winner is the requester with priority under `rr_ptr`. If only one is valid, it wins. rq_ready[winner] is driven combinationally high. Payload and owner are captured; next state ISSUE.
- ISSUE: m_req_valid=1 with the registered payload, held stable until m_req_ready. On handshake, clear `wd_cnt`; next state WAIT.
- WAIT: `wd_cnt` increments each cycle. On m_resp_valid, register the response to the owner: rs_valid[owner]=1, with rs_* copied from m_resp_*. Next state IDLE, and rr_ptr flips to ~owner.
- Watchdog: when `wd_cnt` reaches TIMEOUT_CYCLES-1 without a response, emit rs_valid[owner]=1, rs_resp=2'b10, rs_rdata=0, and rs_is_write=captured we. Set timeout_err; next state IDLE; flip rr_ptr.
- A response and watchdog expiry in the same cycle: the real response wins; timeout_err is not set.
- An m_resp_valid in IDLE or ISSUE is dropped and sets late_resp.
- Requesters hold payload stable while rq_valid && !rq_ready. The arbiter never issues a second request before the first completes.
- `rr_ptr` advances only on completion, never on grant alone.

## Timing
- Reset (rst_n low at a clk edge) forces the following, aborting any transaction in flight without a response:
  - state=IDLE, rr_ptr=0, owner=0, wd_cnt=0
  - rq_ready=0 (IDLE with no valid)
  - m_req_valid=0, m_req_* payload=0
  - rs_valid=0, rs_rdata=0, rs_resp=0, rs_is_write=0
  - timeout_err=0, late_resp=0
- Grant: rq_ready in the same cycle C as rq_valid (IDLE). m_req_valid is first asserted at C+1.
- Zero-stall path: m_req_ready at C+1 puts the FSM in WAIT at C+2.
- Response latency: m_resp_valid at cycle R gives rs_valid at R+1. The FSM is in IDLE at R+1, so a new grant is possible at R+1.
- Minimum request-to-response cost is 3 cycles plus downstream latency.
- rs_valid is exactly one cycle wide.

## Structure
- Package `cache_pkg`: state enum `arb_state_t`, constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
- Single module, no sub-modules. The round-robin pick is a small combinational function inside the module.

## Test plan
- Single read, requester 0 at 0x10, m_req_ready=1, m_resp_rdata=0x12345678 after 4 cycles -> rs_valid[0] pulses with rdata 0x12345678, resp 00, rs_is_write=0; rs_valid[1] stays 0.
- Both valid simultaneously out of reset, req0 write 0x20 and req1 read 0x30 -> req0 granted first; req1 granted in the cycle its predecessor's response appears. Downstream addresses appear in order 0x20, 0x30.
- req0 held valid continuously with req1 valid -> grants alternate 0,1,0,1; no starvation.
- m_req_ready held low 5 cycles -> m_req_valid and payload stay stable for all 5 cycles; single handshake.
- No response for TIMEOUT_CYCLES -> rs_resp=2'b10 to the owner and timeout_err=1. A subsequent stray m_resp_valid sets late_resp and produces no rs_valid.
- rst_n low for one cycle during WAIT -> all outputs return to reset values next cycle and no response is emitted; a fresh request then completes normally.
